// File: rtl/poly_note_player_pkg.sv
// Shared types and the note-to-step ROM contents for poly_note_player.
// Steps are sized for a 22-bit phase accumulator at a 48 kHz sample rate.
package poly_note_player_pkg;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_ADDR = 3'd1,
      ST_WAIT = 3'd2,
      ST_ACC  = 3'd3,
      ST_OUT  = 3'd4
   } mix_state_e;

   localparam int WAVE_SAW   = 0;
   localparam int WAVE_SQR   = 1;
   localparam int ROM_DATA_W = 24;

   // Note 1 is C2; each further note is one equal-tempered semitone up.
   function automatic logic [ROM_DATA_W-1:0] freq_rom_lookup(input logic [7:0] note);
      logic [7:0]            semi;
      logic [3:0]            octave;
      logic [ROM_DATA_W-1:0] base;
      semi   = note - 8'd1;
      octave = 4'd0;
      for (int o = 0; o < 10; o++) begin
         if (semi >= 8'd12) begin
            semi   = semi - 8'd12;
            octave = octave + 4'd1;
         end else begin
            semi   = semi;
         end
      end
      case (semi)
         8'd0:    base = 24'd5715;
         8'd1:    base = 24'd6055;
         8'd2:    base = 24'd6415;
         8'd3:    base = 24'd6796;
         8'd4:    base = 24'd7200;
         8'd5:    base = 24'd7628;
         8'd6:    base = 24'd8082;
         8'd7:    base = 24'd8562;
         8'd8:    base = 24'd9072;
         8'd9:    base = 24'd9611;
         8'd10:   base = 24'd10183;
         8'd11:   base = 24'd10788;
         default: base = 24'd0;
      endcase
      if (note == 8'd0) begin
         return 24'd0;
      end else begin
         return base << octave;
      end
   endfunction

endpackage

// File: rtl/poly_note_player_voice_ctrl.sv
// One voice's note/duration registers: load, beat countdown, done pulse.
module poly_note_player_voice_ctrl
   import poly_note_player_pkg::*;
#(
   parameter int NOTE_W = 6,
   parameter int DUR_W  = 6
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              play_enable,
   input  logic              load,
   input  logic              beat,
   input  logic [NOTE_W-1:0] note_in,
   input  logic [DUR_W-1:0]  dur_in,
   output logic [NOTE_W-1:0] note,
   output logic              done,
   output logic              active
);

   logic [NOTE_W-1:0] note_q, note_d;
   logic [DUR_W-1:0]  dur_q, dur_d;
   logic              done_q, done_d;

   // A load wins over a same-cycle beat; loading duration 0 never pulses done.
   always_comb begin
      note_d = note_q;
      dur_d  = dur_q;
      done_d = 1'b0;
      if (load) begin
         note_d = note_in;
         dur_d  = dur_in;
      end else if (beat && play_enable && (dur_q != {DUR_W{1'b0}})) begin
         dur_d  = dur_q - DUR_W'(1);
         done_d = (dur_q == DUR_W'(1));
      end else begin
         dur_d  = dur_q;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         note_q <= {NOTE_W{1'b0}};
         dur_q  <= {DUR_W{1'b0}};
         done_q <= 1'b0;
      end else begin
         note_q <= note_d;
         dur_q  <= dur_d;
         done_q <= done_d;
      end
   end

   assign note   = note_q;
   assign done   = done_q;
   assign active = (note_q != {NOTE_W{1'b0}}) && (dur_q != {DUR_W{1'b0}});

endmodule

// File: rtl/poly_note_player.sv
// N-voice note player: per-voice duration counters plus a sequential mixer that
// walks every voice through one shared step ROM on each sample strobe.
module poly_note_player
   import poly_note_player_pkg::*;
#(
   parameter  int NUM_VOICES = 4,
   parameter  int NOTE_W     = 6,
   parameter  int DUR_W      = 6,
   parameter  int FREQ_W     = 20,
   parameter  int PHASE_W    = 22,
   parameter  int SAMPLE_W   = 16,
   parameter  int WAVE       = 0,
   localparam int VSEL_W     = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       play_enable,
   input  logic                       load_new_note,
   input  logic [VSEL_W-1:0]          voice_sel,
   input  logic [NOTE_W-1:0]          note_to_load,
   input  logic [DUR_W-1:0]           duration_to_load,
   input  logic                       beat,
   input  logic                       generate_next_sample,
   output logic [NUM_VOICES-1:0]      done_with_note,
   output logic [NUM_VOICES-1:0]      voice_active,
   output logic signed [SAMPLE_W-1:0] sample_out,
   output logic                       new_sample_ready,
   output logic                       overrun
);

   localparam int SHIFT = $clog2(NUM_VOICES);
   localparam int ACC_W = SAMPLE_W + VSEL_W;
   localparam logic signed [ACC_W-1:0] SQR_POS = ACC_W'(2 ** (SAMPLE_W - 2));
   localparam logic signed [ACC_W-1:0] SQR_NEG = -SQR_POS;

   logic [NOTE_W-1:0] voice_note [NUM_VOICES];

   for (genvar g = 0; g < NUM_VOICES; g++) begin : g_voice
      poly_note_player_voice_ctrl #(
         .NOTE_W (NOTE_W),
         .DUR_W  (DUR_W)
      ) u_voice (
         .clk         (clk),
         .reset       (reset),
         .play_enable (play_enable),
         .load        (load_new_note && (voice_sel == VSEL_W'(g))),
         .beat        (beat),
         .note_in     (note_to_load),
         .dur_in      (duration_to_load),
         .note        (voice_note[g]),
         .done        (done_with_note[g]),
         .active      (voice_active[g])
      );
   end

   function automatic logic signed [ACC_W-1:0] wave_of(input logic [PHASE_W-1:0] ph);
      case (WAVE)
         WAVE_SAW: return ACC_W'($signed(ph[PHASE_W-1 -: SAMPLE_W]));
         WAVE_SQR: return ph[PHASE_W-1] ? SQR_NEG : SQR_POS;
         default:  return ACC_W'($signed(ph[PHASE_W-1 -: SAMPLE_W]));
      endcase
   endfunction

   mix_state_e                  state_q, state_d;
   logic [VSEL_W-1:0]           idx_q, idx_d;
   logic signed [ACC_W-1:0]     acc_q, acc_d;
   logic [FREQ_W-1:0]           step_q, step_d;
   logic [PHASE_W-1:0]          phase_q [NUM_VOICES];
   logic [PHASE_W-1:0]          phase_d [NUM_VOICES];
   logic signed [SAMPLE_W-1:0]  sample_q, sample_d;
   logic                        ready_q, ready_d;
   logic                        overrun_q, overrun_d;

   // Registered ROM read: address presented in ADDR, step valid from WAIT onward.
   always_comb begin
      step_d = FREQ_W'(freq_rom_lookup(8'(voice_note[idx_q])));
   end

   // Mix sequencer, phase update and overrun tracking.
   always_comb begin
      state_d   = state_q;
      idx_d     = idx_q;
      acc_d     = acc_q;
      phase_d   = phase_q;
      sample_d  = sample_q;
      ready_d   = 1'b0;
      overrun_d = overrun_q;
      case (state_q)
         ST_IDLE: begin
            if (generate_next_sample && play_enable) begin
               acc_d   = {ACC_W{1'b0}};
               idx_d   = {VSEL_W{1'b0}};
               state_d = ST_ADDR;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_ADDR: state_d = ST_WAIT;
         ST_WAIT: state_d = ST_ACC;
         ST_ACC: begin
            if (voice_active[idx_q]) begin
               phase_d[idx_q] = phase_q[idx_q] + PHASE_W'(step_q);
               acc_d          = acc_q + wave_of(phase_q[idx_q]);
            end else begin
               phase_d[idx_q] = {PHASE_W{1'b0}};
            end
            if (idx_q == VSEL_W'(NUM_VOICES - 1)) begin
               state_d = ST_OUT;
            end else begin
               idx_d   = idx_q + VSEL_W'(1);
               state_d = ST_ADDR;
            end
         end
         ST_OUT: begin
            sample_d = SAMPLE_W'(acc_q >>> SHIFT);
            ready_d  = 1'b1;
            state_d  = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
      if (generate_next_sample && (state_q != ST_IDLE)) begin
         overrun_d = 1'b1;
      end else begin
         overrun_d = overrun_q;
      end
      // A load restarts that voice's waveform even if the mixer just advanced it.
      if (load_new_note) begin
         phase_d[voice_sel] = {PHASE_W{1'b0}};
      end else begin
         phase_d[voice_sel] = phase_d[voice_sel];
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q   <= ST_IDLE;
         idx_q     <= {VSEL_W{1'b0}};
         acc_q     <= {ACC_W{1'b0}};
         step_q    <= {FREQ_W{1'b0}};
         phase_q   <= '{default: {PHASE_W{1'b0}}};
         sample_q  <= {SAMPLE_W{1'b0}};
         ready_q   <= 1'b0;
         overrun_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         idx_q     <= idx_d;
         acc_q     <= acc_d;
         step_q    <= step_d;
         phase_q   <= phase_d;
         sample_q  <= sample_d;
         ready_q   <= ready_d;
         overrun_q <= overrun_d;
      end
   end

   assign sample_out       = sample_q;
   assign new_sample_ready = ready_q;
   assign overrun          = overrun_q;

endmodule
